// File: rtl/as_sequencer.sv
// Fetch/decode/sequence controller for the as processor: owns pc, IR and the FETCH/EXEC/HALT machine.
// Optional single-step mode (step port plus STEP state) is enabled by defining AS_SEQ_STEP_EN.
module as_sequencer #(
   parameter int unsigned n    = 8,
   parameter int unsigned PC_W = 8
) (
   input  logic            clk,
   input  logic            n_reset,
`ifdef AS_SEQ_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_valid,
   input  logic [15:0]     imem_data,
   input  logic            z,
   output logic [1:0]      rd_addr,
   output logic [1:0]      rs_addr,
   output logic [n-1:0]    immediate,
   output logic            reg_we,
   output logic            add_a_sel,
   output logic            add_b_sel,
   output logic            acc_en,
   output logic            acc_add,
   output logic            in_en,
   output logic            halted
);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_MAC  = 4'h2;
   localparam logic [3:0] OP_IN   = 4'h3;
   localparam logic [3:0] OP_ACCL = 4'h4;
   localparam logic [3:0] OP_ACCI = 4'h5;
   localparam logic [3:0] OP_BSW  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2,
      S_STEP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;

   logic [3:0]        op;
   logic [PC_W-1:0]   target;
   logic [n-1:0]      imm_ext;
   logic              branch;

   assign op     = ir_q[15:12];
   assign target = ir_q[PC_W+3:4];
   assign branch = (op == OP_JMP) || ((op == OP_BSW) && z);

   // The 8-bit immediate field is sign-extended to wide datapaths, truncated to narrow ones.
   if (n > 8) begin : g_imm_sext
      assign imm_ext = {{(n-8){ir_q[7]}}, ir_q[7:0]};
   end else begin : g_imm_trunc
      assign imm_ext = ir_q[n-1:0];
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pc_d = branch ? target : pc_q + PC_W'(1);
            if (op == OP_HALT) begin
               state_d = S_HALT;
            end else begin
`ifdef AS_SEQ_STEP_EN
               state_d = S_STEP;
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         S_STEP: begin
`ifdef AS_SEQ_STEP_EN
            if (step) state_d = S_FETCH;
`else
            state_d = S_FETCH;
`endif
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign imem_addr = pc_q;
   assign imem_req  = (state_q == S_FETCH);
   assign halted    = (state_q == S_HALT);
   assign rd_addr   = ir_q[11:10];
   assign rs_addr   = ir_q[9:8];
   // BSW drives the constant 1 so the adder sees {n{SW8}}+1 and z mirrors SW[8].
   assign immediate = (op == OP_BSW) ? n'(1) : imm_ext;

   // Strobes decode straight from IR and are gated to the single EXEC cycle.
   always_comb begin
      reg_we    = 1'b0;
      add_a_sel = 1'b0;
      add_b_sel = 1'b0;
      acc_en    = 1'b0;
      acc_add   = 1'b0;
      in_en     = 1'b0;
      if (state_q == S_EXEC) begin
         case (op)
            OP_ADDI: begin
               add_b_sel = 1'b1;
               reg_we    = 1'b1;
            end
            OP_MAC: begin
               reg_we    = 1'b1;
            end
            OP_IN: begin
               in_en     = 1'b1;
               reg_we    = 1'b1;
            end
            OP_ACCL: begin
               add_b_sel = 1'b1;
               acc_en    = 1'b1;
            end
            OP_ACCI: begin
               acc_add   = 1'b1;
               add_b_sel = 1'b1;
               acc_en    = 1'b1;
            end
            OP_BSW: begin
               add_a_sel = 1'b1;
               add_b_sel = 1'b1;
            end
            OP_NOP, OP_JMP, OP_HALT: ;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/as_sequencer.md
Name: as_sequencer

Overview:
- Instruction fetch/decode/sequence controller for the as embedded processor.
- Fetches 16-bit instructions from instruction memory using a req/valid handshake.
- Decodes each instruction into the datapath control strobes, register addresses and immediate that the ALU and register file consume.
- Samples the ALU zero flag to resolve branches.
- Owns the program counter and the FETCH/EXEC/HALT state machine.

Parameters:
- n, 8, datapath width; width of the immediate output.
- PC_W, 8, program counter width; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- imem_addr  output  PC_W  instruction address; equals pc.
- imem_req  output  1  fetch request.
- imem_valid  input  1  imem_data valid; completes the fetch.
- imem_data  input  16  instruction word.
- z  input  1  ALU zero flag for the current EXEC cycle.
- rd_addr  output  2  destination/source register, IR[11:10].
- rs_addr  output  2  source register, IR[9:8].
- immediate  output  n  immediate operand to the ALU.
- reg_we  output  1  register file write enable.
- add_a_sel, add_b_sel, acc_en, acc_add, in_en  output  1 each  ALU control strobes.
- halted  output  1  high in the HALT state.

Behaviour:
- Instruction format: opcode IR[15:12]; rd IR[11:10]; rs IR[9:8]; imm IR[7:0]; target IR[PC_W+3:4].
- immediate = imm, sign-extended or truncated to n bits.
- Reset (asynchronous, any state, mid-fetch included):
  - state FETCH, pc 0, IR 0.
  - All EXEC strobes 0, halted 0.
  - In-flight fetch is abandoned; no register or ACC write occurs.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - Stay in FETCH while imem_valid=0.
  - When imem_valid=1: IR<=imem_data, go to EXEC next cycle.
  - imem_valid is ignored outside FETCH.
- EXEC state:
  - Lasts exactly one cycle. Strobes are combinational from IR and are active only in EXEC; all strobes are 0 in every other state.
  - imem_req=0 in EXEC and HALT.
  - Next state is FETCH, except HALT for opcode 0xF.
  - pc updates at the EXEC exit edge: pc <= pc+1 (mod 2^PC_W) unless the instruction branches.
- Opcode decode (strobes not listed are 0):
  - 0x0 NOP: no strobes.
  - 0x1 ADDI: add_b_sel=1, reg_we=1. Result: rd <= rd+imm.
  - 0x2 MAC: add_b_sel=0, reg_we=1. Result: rd <= rd + int(rs*imm).
  - 0x3 IN: in_en=1, reg_we=1. Result: rd <= SW[7:0].
  - 0x4 ACCL: add_b_sel=1, acc_en=1. Result: ACC <= rd+imm.
  - 0x5 ACCI: acc_add=1, add_b_sel=1, acc_en=1. Result: ACC <= ACC+imm.
  - 0x6 BSW:
    - Strobes: add_a_sel=1, add_b_sel=1, immediate forced to 1, reg_we=0.
    - The adder computes {n{SW8}}+1, so z=1 exactly when SW[8]=1.
    - Branch taken when z=1: pc <= target; otherwise pc+1.
  - 0x7 JMP: pc <= target, no strobes.
  - 0xF HALT: enter HALT.
  - 0x8–0xE: treated as NOP.
- HALT state:
  - halted=1, pc frozen, no fetch.
  - Left only by reset.
- Boundaries:
  - pc at 2^PC_W−1 with a non-branch instruction wraps to 0.
  - imem_valid asserted in the same cycle the state enters FETCH is accepted; minimum throughput is 2 cycles per instruction.
  - z is sampled only in EXEC of BSW; ignored otherwise.

Optional Feature:
- Macro: AS_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and a STEP state between EXEC and FETCH.
  - The state machine waits in STEP, with all strobes 0 and imem_req=0, until step=1, then goes to FETCH.
  - step is sampled as a level.
  - HALT still takes priority from EXEC.
- Not defined: no step port; EXEC goes directly to FETCH.

Test Plan:
- Reset then imem_valid held 1 with ADDI r1,#5 (0x1405) at addr 0:
  - imem_req=1, imem_addr=0 in the first cycle.
  - Next cycle: reg_we=1, add_b_sel=1, rd_addr=1, immediate=0x05.
  - Then imem_addr=1.
- imem_valid delayed 3 cycles:
  - imem_req holds 1 and imem_addr holds stable.
  - No strobes until the cycle after imem_valid.
- BSW target 0x20 (0x6200):
  - z=1: next imem_addr=0x20.
  - z=0: next imem_addr=pc+1.
  - immediate=1, add_a_sel=1 in EXEC.
- JMP 0xFF, then NOP at 0xFF: next fetch address is 0x00 (wrap).
- ACCI #3 (0x5003): acc_add=1, acc_en=1, add_b_sel=1, reg_we=0 for exactly one cycle.
- HALT (0xF000):
  - halted=1, imem_req=0 held for 10 cycles.
  - n_reset pulse low: halted=0, imem_addr=0, imem_req=1.
- Reset asserted mid-FETCH: all outputs return to reset values immediately.
